// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM state encoding, UART frame
// constants and a small index helper.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    HOLD      = 3'd4
  } arb_state_e;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = UART_DATA_BITS + 2;

  // Next index after idx, wrapping at n (n need not be a power of two).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set mask bit at or after ptr,
// wrapping, returned one-hot together with a found flag.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          valid
);

  logic [PW-1:0] idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!valid && mask[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams,
// with packet lock until a byte flagged last, plus ack and hold watchdogs.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int HOLD_TIMEOUT = 4800,
  parameter int ACK_TIMEOUT  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [8*NUM_REQ-1:0]      req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic [UART_DATA_BITS-1:0] tx_data,
  output logic                      tx_send,
  input  logic                      tx_busy,
  output logic                      err_ack,
  output logic                      err_hold
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int HW = $clog2(HOLD_TIMEOUT);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);

  arb_state_e                state, state_d;
  logic [PW-1:0]             ptr, ptr_d;
  logic [PW-1:0]             owner, owner_d;
  logic [NUM_REQ-1:0]        grant_d;
  logic [UART_DATA_BITS-1:0] tx_data_d;
  logic                      last_q, last_d;
  logic [HW-1:0]             hold_cnt, hold_d;
  logic [AW-1:0]             ack_cnt, ack_d;
  logic                      armed;

  logic [NUM_REQ-1:0]        pick_oh;
  logic                      pick_valid;
  logic [NUM_REQ-1:0]        sel_oh;
  logic [PW-1:0]             sel_idx;
  logic [UART_DATA_BITS-1:0] sel_data;
  logic                      sel_last;
  logic [PW-1:0]             owner_next;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .mask  (req_valid),
    .ptr   (ptr),
    .pick  (pick_oh),
    .valid (pick_valid)
  );

  // While locked only the owner's byte is of interest; otherwise the fresh pick.
  always_comb begin
    sel_oh   = (state == HOLD) ? grant : pick_oh;
    sel_idx  = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_oh[i]) begin
        sel_idx  = sel_idx | PW'(i);
        sel_data = sel_data | req_data[8*i +: 8];
        sel_last = sel_last | req_last[i];
      end
    end
  end

  assign owner_next = PW'(wrap_inc(int'(owner), NUM_REQ));

  // armed keeps req_ready low during reset and for the first cycle after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      grant    <= '0;
      tx_data  <= '0;
      last_q   <= 1'b0;
      hold_cnt <= '0;
      ack_cnt  <= '0;
      armed    <= 1'b0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      owner    <= owner_d;
      grant    <= grant_d;
      tx_data  <= tx_data_d;
      last_q   <= last_d;
      hold_cnt <= hold_d;
      ack_cnt  <= ack_d;
      armed    <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    owner_d   = owner;
    grant_d   = grant;
    tx_data_d = tx_data;
    last_d    = last_q;
    hold_d    = hold_cnt;
    ack_d     = ack_cnt;
    req_ready = '0;
    tx_send   = 1'b0;
    err_ack   = 1'b0;
    err_hold  = 1'b0;

    case (state)
      IDLE: begin
        if (armed && pick_valid && !tx_busy) begin
          req_ready = pick_oh;
          grant_d   = pick_oh;
          owner_d   = sel_idx;
          tx_data_d = sel_data;
          last_d    = sel_last;
          state_d   = ISSUE;
        end
      end

      ISSUE: begin
        tx_send = 1'b1;
        ack_d   = '0;
        state_d = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
          err_ack = 1'b1;
          grant_d = '0;
          ptr_d   = owner_next;
          state_d = IDLE;
        end else begin
          ack_d = ack_cnt + 1'b1;
        end
      end

      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_d = '0;
            ptr_d   = owner_next;
            state_d = IDLE;
          end else begin
            hold_d  = '0;
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (|(req_valid & grant) && !tx_busy) begin
          req_ready = grant;
          tx_data_d = sel_data;
          last_d    = sel_last;
          state_d   = ISSUE;
        end else if (hold_cnt == HW'(HOLD_TIMEOUT - 1)) begin
          err_hold = 1'b1;
          grant_d  = '0;
          ptr_d    = owner_next;
          state_d  = IDLE;
        end else begin
          hold_d = hold_cnt + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
